// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver with a 2-flop input synchronizer.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop (8E1).
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       CP,
    input  logic       RST,
    input  logic       In,
    output logic [7:0] Data,
    output logic       Valid,
    output logic       FrameErr,
    output logic       Busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd3;
`endif
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             syncMeta;
    logic             rxS;
    logic             bitEnd;
    logic             halfEnd;
`ifdef UART_RX_PARITY_EN
    logic             parityBit;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge CP) begin
        if (RST) begin
            syncMeta <= 1'b1;
            rxS      <= 1'b1;
        end else begin
            syncMeta <= In;
            rxS      <= syncMeta;
        end
    end

    assign bitEnd  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign halfEnd = (cnt == CNT_W'(HALF_BIT - 1));
    assign Busy    = (state != IDLE);

    // Frame sequencer: the start bit is re-checked at its centre, and every later
    // sample lands one full bit period after the previous centre sample.
    always_ff @(posedge CP) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bitIdx    <= 3'd0;
            shiftReg  <= 8'h00;
            Data      <= 8'h00;
            Valid     <= 1'b0;
            FrameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxS) begin
                        state <= START;
                    end
                end
                START: begin
                    if (halfEnd) begin
                        cnt    <= '0;
                        bitIdx <= 3'd0;
                        state  <= rxS ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        cnt              <= '0;
                        shiftReg[bitIdx] <= rxS;
                        if (bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bitIdx <= bitIdx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bitEnd) begin
                        cnt       <= '0;
                        parityBit <= rxS;
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bitEnd) begin
                        cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        if (rxS && (parityBit == ^shiftReg)) begin
`else
                        if (rxS) begin
`endif
                            Data  <= shiftReg;
                            Valid <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // A low stop bit may be a break; wait for the line to recover.
                            FrameErr <= 1'b1;
                            state    <= rxS ? IDLE : WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    cnt <= '0;
                    if (rxS) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; frames are driven bit by bit and a
// monitor checks every Valid/FrameErr strobe against the expected-event queue.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       CP  = 1'b0;
    logic       RST = 1'b1;
    logic       In  = 1'b1;
    logic [7:0] Data;
    logic       Valid;
    logic       FrameErr;
    logic       Busy;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monItem;
    int         errors = 0;
    int         checks = 0;
    int         cycle = 0;
    int         validCount = 0;
    int         lastValidCycle = 0;
    int         lastStartCycle = 0;
    logic [7:0] lastGood = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .CP(CP),
        .RST(RST),
        .In(In),
        .Data(Data),
        .Valid(Valid),
        .FrameErr(FrameErr),
        .Busy(Busy)
    );

    always #5 CP = ~CP;

    always @(posedge CP) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Reference: a frame yields a byte when its stop bit (and parity, if enabled)
    // is good, otherwise one error strobe with the last good byte still on Data.
    function automatic void expectFrame(input logic [7:0] b, input bit stopBit, input bit parityBit);
        bit ok;
        ok = stopBit;
`ifdef UART_RX_PARITY_EN
        ok = ok && (parityBit == ^b);
`endif
        if (ok) begin
            expQ.push_back('{isErr: 1'b0, data: b});
            lastGood = b;
        end else begin
            expQ.push_back('{isErr: 1'b1, data: lastGood});
        end
    endfunction

    task automatic driveBit(input logic b, input int n);
        In = b;
        if (n > 0) begin
            repeat (n) @(posedge CP);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input bit parityBit);
        expectFrame(b, stopBit, parityBit);
        lastStartCycle = cycle;
        driveBit(1'b0, CPB);
        for (int i = 0; i < 8; i++) driveBit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        driveBit(parityBit, CPB);
`endif
        driveBit(stopBit, CPB);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40 * CPB && expQ.size() != 0; i++) @(posedge CP);
        #1;
        checkOutput("drain", expQ.size(), 0);
    endtask

    // Monitor: every output strobe must match the oldest expected event.
    always @(negedge CP) begin
        if (Valid || FrameErr) begin
            checkOutput("exclusive", Valid && FrameErr, 1'b0);
            if (Valid) begin
                validCount++;
                lastValidCycle = cycle;
            end
            if (expQ.size() == 0) begin
                checkOutput("unexpected_strobe", {Valid, FrameErr}, 2'b00);
            end else begin
                monItem = expQ.pop_front();
                checkOutput("strobe_kind", FrameErr, monItem.isErr);
                checkOutput("data", Data, monItem.data);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v0;
        int lat;
        bit sawBusy;
        string hello;
        logic [7:0] b;
        bit bad;

        RST = 1'b1;
        repeat (3) @(posedge CP);
        #1 RST = 1'b0;
        @(negedge CP);
        checkOutput("reset_data", Data, 8'h00);
        checkOutput("reset_valid", Valid, 1'b0);
        checkOutput("reset_frameerr", FrameErr, 1'b0);
        checkOutput("reset_busy", Busy, 1'b0);
        repeat (2 * CPB) @(posedge CP);
        #1;

        $display("[TB] single byte 'H'");
        v0 = validCount;
        applyStimulus(8'h48, 1'b1, ^8'h48);
        @(negedge CP);
        checkOutput("busy_after_stop", Busy, 1'b0);
        waitDrain();
        checkOutput("h_valid_count", validCount - v0, 1);
        lat = lastValidCycle - lastStartCycle;
        checks++;
        if (lat < 154 || lat > 156) begin
            errors++;
            $display("[TB] FAIL latency: got %0d, want 155 +/- 1", lat);
        end

        $display("[TB] Hello World back-to-back");
        hello = "Hello World";
        v0 = validCount;
        @(posedge CP);
        #1;
        for (int i = 0; i < hello.len(); i++) applyStimulus(hello[i], 1'b1, ^hello[i]);
        waitDrain();
        checkOutput("hello_valid_count", validCount - v0, 11);

        $display("[TB] start-bit glitch");
        driveBit(1'b0, 4);
        In = 1'b1;
        sawBusy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CP);
            if (Busy) sawBusy = 1'b1;
        end
        checkOutput("glitch_busy_pulse", sawBusy, 1'b1);
        checkOutput("glitch_busy_clear", Busy, 1'b0);
        @(posedge CP);
        #1;
        applyStimulus(8'hA5, 1'b1, ^8'hA5);
        waitDrain();

        $display("[TB] bad stop bit then break");
        applyStimulus(8'h55, 1'b0, ^8'h55);
        driveBit(1'b0, 40 * CPB);
        driveBit(1'b1, 2 * CPB);
        waitDrain();
        checkOutput("break_data_held", Data, 8'hA5);
        applyStimulus(8'h0F, 1'b1, ^8'h0F);
        waitDrain();

        $display("[TB] reset mid-frame");
        b = 8'h3C;
        driveBit(1'b0, CPB);
        for (int i = 0; i < 4; i++) driveBit(b[i], CPB);
        driveBit(b[4], CPB / 2);
        RST = 1'b1;
        @(posedge CP);
        #1;
        RST = 1'b0;
        In = 1'b1;
        lastGood = 8'h00;
        @(negedge CP);
        checkOutput("midreset_data", Data, 8'h00);
        checkOutput("midreset_busy", Busy, 1'b0);
        checkOutput("midreset_valid", Valid, 1'b0);
        repeat (3 * CPB) @(posedge CP);
        #1;
        applyStimulus(8'hC3, 1'b1, ^8'hC3);
        waitDrain();
        checkOutput("after_reset_data", Data, 8'hC3);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity");
        applyStimulus(8'h07, 1'b1, 1'b1);
        applyStimulus(8'h07, 1'b1, 1'b0);
        driveBit(1'b1, CPB);
        waitDrain();
`endif

        $display("[TB] random frames");
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            applyStimulus(b, !bad, ^b);
            if (bad) begin
                driveBit(1'b0, $urandom_range(0, 3 * CPB));
                driveBit(1'b1, CPB);
            end else begin
                driveBit(1'b1, $urandom_range(0, 2 * CPB));
            end
        end
        waitDrain();
        repeat (2 * CPB) @(posedge CP);
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver, the receive end of the link that the transmit-side blocks (e.g. the HelloWorld string sender) drive.
- Oversamples the idle-high line In and frames 8N1 characters.
- Presents each received byte with a one-cycle valid strobe; flags bad stop bits.
- Used to loop back and check transmitter output in simulation and on board.

Parameters:
CLKS_PER_BIT, 434, CP cycles per UART bit (50 MHz / 115200); must be >= 4.
CNT_W, 16, width of the bit-timing counter; must hold CLKS_PER_BIT-1.

Ports:
CP  input  1  clock, all logic on rising edge
RST  input  1  reset, synchronous, active-high
In  input  1  asynchronous serial line, idle high
Data  output  8  last received byte, LSB received first
Valid  output  1  one-cycle pulse: Data updated with a good frame
FrameErr  output  1  one-cycle pulse: stop bit sampled low (or parity fail, see option)
Busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (RST high at a CP edge):
  - Data=8'h00, Valid=0, FrameErr=0, Busy=0.
  - State=IDLE; both synchronizer flops=1; counter and bit index=0.
  - RST mid-frame discards the partial byte. No Valid or FrameErr is issued for it.
- Synchronizer: In passes through 2 flops; all decisions use the second flop (rx_s). The 2-cycle input delay is part of the latency.
- State machine: IDLE -> START -> DATA -> STOP -> (WAIT_HIGH ->) IDLE.
  - IDLE: when rx_s=0, go to START with counter=0.
  - START: count to CLKS_PER_BIT/2-1 (integer divide), then sample rx_s.
    - 0: go to DATA with counter=0, bit index=0.
    - 1: glitch; return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles (counter wraps at CLKS_PER_BIT-1), sample rx_s into shift reg bit [index]. After index 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: Data<=shift reg; Valid=1 for exactly the next cycle; go to IDLE.
    - 0: FrameErr=1 for one cycle; Data unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A held-low line (break) produces exactly one FrameErr, never repeats.
- Latency: Valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the In falling edge.
- Back-to-back frames: a new start bit may begin the cycle after the STOP sample. No idle gap is required, and no byte is lost at full line rate.
- Data holds its value between frames. Valid and FrameErr are never high together.
- Busy is high from the IDLE->START transition through the STOP/WAIT_HIGH exit.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - A PARITY state sits between DATA and STOP and samples an even-parity bit after CLKS_PER_BIT.
  - At STOP, Valid requires stop=1 and parity ok.
  - Parity mismatch with stop=1: FrameErr pulse, Data unchanged, go to IDLE.
  - Frame length is 11 bits; latency grows by CLKS_PER_BIT.
- Undefined: 8N1 only; no PARITY state is present in the RTL.

Test Plan:
- CLKS_PER_BIT=16; RST 3 cycles then idle; drive 'H' (0x48) 8N1 -> Valid one cycle, Data=8'h48, FrameErr never high, Busy returns 0 after the stop sample.
- Drive "Hello World" (11 bytes) back-to-back with no gap -> 11 Valid pulses, in order: 48 65 6C 6C 6F 20 57 6F 72 6C 64; no FrameErr.
- Low glitch of 4 cycles on In (< 8 = half bit) -> no Valid/FrameErr; Busy pulses then returns 0; next byte 0xA5 is received correctly.
- 0x55 with stop bit=0, then line held low 40 bit times, then high -> exactly one FrameErr, Data keeps the previous value; following 0x0F received with Valid.
- RST asserted 1 cycle mid-way through bit 4 of 0x3C -> outputs 0, no Valid for 0x3C; next 0xC3 -> Data=8'hC3.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> Valid; 0x07 with parity 0 -> FrameErr, no Valid.
